// File: rtl/stash_ctrl_pkg.sv
// Shared types and width helpers for the lap-sample stash sequencing controller.
package stash_ctrl_pkg;

    typedef enum logic [1:0] {
        StLive   = 2'd0,
        StBrowse = 2'd1,
        StAuto   = 2'd2
    } state_e;

    // Width of a saturating 0..depth sample counter.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a 0..depth-1 slot index, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stash_ctrl_auto_timer.sv
// Free-running scroll timer: counts 0..PERIOD-1 while enabled and flags the terminal count.
module auto_timer #(
    parameter int unsigned PERIOD = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    // A clear in the terminal cycle wins, so the restarted period is never cut short.
    assign tick = enable && !clear && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !enable || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/stash_ctrl.sv
// Turns button pulses into stash capture/advance strobes, runs browse/auto-scroll
// and keeps capture and advance strobes from ever coinciding.
module stash_ctrl
    import stash_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 5,
    parameter int unsigned AUTO_PERIOD = 100_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic [7:0]                     time_in,
    input  logic                           lap_btn,
    input  logic                           browse_btn,
    input  logic                           auto_btn,
    input  logic                           exit_btn,
    output logic [7:0]                     sample_in,
    output logic                           sample_in_valid,
    output logic                           next_sample,
    output logic                           show_stash,
    output logic [cnt_width(DEPTH)-1:0]    stored_cnt,
    output logic [idx_width(DEPTH)-1:0]    sel_idx
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned IW = idx_width(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    state_e        state;
    state_e        state_next;
    logic [IW-1:0] wr_ptr;
    logic          pending;
    logic          capture;
    logic          adv_req;
    logic          auto_entry;
    logic          issue_adv;
    logic          tick;

    auto_timer #(
        .PERIOD (AUTO_PERIOD)
    ) u_auto_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture || auto_entry),
        .enable (state == StAuto),
        .tick   (tick)
    );

    always_comb begin
        capture    = lap_btn && run;
        adv_req    = 1'b0;
        auto_entry = 1'b0;
        state_next = state;
        case (state)
            StLive: begin
                if (browse_btn && (stored_cnt != '0)) state_next = StBrowse;
            end
            StBrowse: begin
                if (exit_btn) begin
                    state_next = StLive;
                end else if (browse_btn) begin
                    adv_req = 1'b1;
                end else if (auto_btn) begin
                    state_next = StAuto;
                    auto_entry = 1'b1;
                end
            end
            StAuto: begin
                if (exit_btn)        state_next = StLive;
                else if (browse_btn) state_next = StBrowse;
                else if (tick)       adv_req = 1'b1;
            end
            default: state_next = StLive;
        endcase
        // An advance never shares a cycle with a capture; it waits in pending instead.
        issue_adv = (adv_req || pending) && !capture && !exit_btn;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= StLive;
            wr_ptr          <= '0;
            pending         <= 1'b0;
            sample_in       <= '0;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
            show_stash      <= 1'b0;
            stored_cnt      <= '0;
            sel_idx         <= '0;
        end else begin
            state           <= state_next;
            show_stash      <= (state_next != StLive);
            sample_in_valid <= capture;
            next_sample     <= issue_adv;
            pending         <= !exit_btn && capture && (pending || adv_req);
            if (capture) begin
                sample_in <= time_in;
                sel_idx   <= wr_ptr;
                wr_ptr    <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + IW'(1);
                if (stored_cnt != FULL_CNT) stored_cnt <= stored_cnt + CW'(1);
            end else if (issue_adv) begin
                sel_idx <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stash_ctrl.sv
// Scoreboard bench for stash_ctrl: directed stimulus queues expected strobes, a monitor checks them.
module tb_stash_ctrl;
    import stash_ctrl_pkg::*;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned PER   = 4;
    localparam int unsigned CW    = cnt_width(DEPTH);
    localparam int unsigned IW    = idx_width(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [7:0]    time_in = 8'h00;
    logic          lap_btn = 1'b0;
    logic          browse_btn = 1'b0;
    logic          auto_btn = 1'b0;
    logic          exit_btn = 1'b0;
    logic [7:0]    sample_in;
    logic          sample_in_valid;
    logic          next_sample;
    logic          show_stash;
    logic [CW-1:0] stored_cnt;
    logic [IW-1:0] sel_idx;

    stash_ctrl #(
        .DEPTH       (DEPTH),
        .AUTO_PERIOD (PER)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run             (run),
        .time_in         (time_in),
        .lap_btn         (lap_btn),
        .browse_btn      (browse_btn),
        .auto_btn        (auto_btn),
        .exit_btn        (exit_btn),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample),
        .show_stash      (show_stash),
        .stored_cnt      (stored_cnt),
        .sel_idx         (sel_idx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_adv;
        int unsigned at;
        logic [7:0]  data;
        int unsigned sel;
        int unsigned cnt;
        bit          show;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned now = 0;
    int unsigned c = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_cap(input int unsigned at, input logic [7:0] d, input int unsigned sel,
                           input int unsigned cnt, input bit show);
        exp_t e;
        e.is_adv = 1'b0; e.at = at; e.data = d; e.sel = sel; e.cnt = cnt; e.show = show;
        sb.push_back(e);
    endtask

    task automatic exp_adv(input int unsigned at, input int unsigned sel,
                           input int unsigned cnt, input bit show);
        exp_t e;
        e.is_adv = 1'b1; e.at = at; e.data = 8'h00; e.sel = sel; e.cnt = cnt; e.show = show;
        sb.push_back(e);
    endtask

    task automatic drive(input bit l, input bit b, input bit a, input bit x, input logic [7:0] t);
        @(negedge clk);
        lap_btn = l; browse_btn = b; auto_btn = a; exit_btn = x; time_in = t;
        now = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, time_in);
    endtask

    // Monitor: samples 2 time units after each active edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: got nothing at cycle %0d, required %s", e.at,
                     e.is_adv ? "next_sample" : "sample_in_valid");
        end
        if (sample_in_valid || next_sample) begin
            check("no_overlap", {31'b0, sample_in_valid & next_sample}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got valid=%b next=%b at cycle %0d, required none",
                         sample_in_valid, next_sample, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {31'b0, next_sample}, {31'b0, e.is_adv});
                check("pulse_cycle", cyc, e.at);
                if (!e.is_adv) check("sample_in", {24'b0, sample_in}, {24'b0, e.data});
                check("pulse_sel_idx", 32'(sel_idx), e.sel);
                check("pulse_stored_cnt", 32'(stored_cnt), e.cnt);
                check("pulse_show_stash", {31'b0, show_stash}, {31'b0, e.show});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_sample_in", {24'b0, sample_in}, 32'd0);
        check("rst_valid", {31'b0, sample_in_valid}, 32'd0);
        check("rst_next", {31'b0, next_sample}, 32'd0);
        check("rst_show", {31'b0, show_stash}, 32'd0);
        check("rst_cnt", 32'(stored_cnt), 32'd0);
        check("rst_sel", 32'(sel_idx), 32'd0);

        // Browse with nothing stored stays LIVE.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(2);
        check("empty_browse_show", {31'b0, show_stash}, 32'd0);

        // Three captures.
        run = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11); exp_cap(now + 1, 8'h11, 0, 1, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h22); exp_cap(now + 1, 8'h22, 1, 2, 1'b0);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h33); exp_cap(now + 1, 8'h33, 2, 3, 1'b0);
        idle(2);
        check("three_cnt", 32'(stored_cnt), 32'd3);
        check("three_sel", 32'(sel_idx), 32'd2);
        check("three_show", {31'b0, show_stash}, 32'd0);

        // Lap while stopped is ignored.
        run = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5a);
        idle(2);
        run = 1'b1;
        check("stopped_lap_cnt", 32'(stored_cnt), 32'd3);

        // Enter BROWSE without advancing, then advance manually.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        check("browse_show", {31'b0, show_stash}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); exp_adv(now + 1, 3, 3, 1'b1);
        idle(2);

        // Collision: advance deferred past the capture.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h44);
        exp_cap(now + 1, 8'h44, 3, 4, 1'b1);
        exp_adv(now + 2, 4, 4, 1'b1);
        idle(2);

        // Back-to-back captures with merged requests; count saturates, wr_ptr wraps.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h55); c = now; exp_cap(c + 1, 8'h55, 4, 5, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h66); exp_cap(c + 2, 8'h66, 0, 5, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h77); exp_cap(c + 3, 8'h77, 1, 5, 1'b1);
        exp_adv(c + 4, 2, 5, 1'b1);
        idle(3);
        check("sat_cnt", 32'(stored_cnt), 32'd5);

        // Exit returns to LIVE; exit also drops a pending advance.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);
        check("exit_show", {31'b0, show_stash}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h88); exp_cap(now + 1, 8'h88, 2, 5, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(3);
        check("exit_pending_sel", 32'(sel_idx), 32'd2);
        check("exit_pending_show", {31'b0, show_stash}, 32'd0);

        // AUTO scroll every PER cycles; a lap restarts the period.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00); c = now;
        exp_adv(c + 1 + PER, 3, 5, 1'b1);
        exp_adv(c + 1 + 2 * PER, 4, 5, 1'b1);
        idle(9);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        exp_cap(c + 11, 8'h99, 3, 5, 1'b1);
        exp_adv(c + 11 + PER, 4, 5, 1'b1);
        idle(4);

        // Asynchronous reset in the middle of an advance pulse.
        @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        check("async_rst_next", {31'b0, next_sample}, 32'd0);
        check("async_rst_valid", {31'b0, sample_in_valid}, 32'd0);
        check("async_rst_show", {31'b0, show_stash}, 32'd0);
        check("async_rst_cnt", 32'(stored_cnt), 32'd0);
        check("async_rst_sel", 32'(sel_idx), 32'd0);
        check("async_rst_sample", {24'b0, sample_in}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        check("post_rst_show", {31'b0, show_stash}, 32'd0);

        idle(2);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expect: got nothing, required pulse at cycle %0d", e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stash_ctrl.md
# stash_ctrl

Sequencing controller for the lap-sample stash in the stopwatch design. Converts debounced single-cycle button pulses into the stash's `sample_in`/`sample_in_valid`/`next_sample` strobes and guarantees that a capture and an advance never coincide. It also runs manual or auto-scroll browsing and drives the display-source select between the live stopwatch time and the stash output. It sits between the button debouncers and the stash, alongside the stopwatch counter.

## Interface
- `DEPTH`, 5: stash capacity. Must equal the stash's `DEPTH`.
- `AUTO_PERIOD`, 100_000_000: cycles between automatic advances in AUTO (1 s at 100 MHz). Must be ≥ 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset. The same net also resets the stash.
- `run` in 1: stopwatch running flag.
- `time_in` in 8: current stopwatch value.
- `lap_btn` in 1: one-cycle pulse that requests a capture.
- `browse_btn` in 1: one-cycle pulse that enters browse or advances manually.
- `auto_btn` in 1: one-cycle pulse that enters AUTO from BROWSE.
- `exit_btn` in 1: one-cycle pulse that returns to LIVE.
- `sample_in` out 8: captured time value, connected to the stash.
- `sample_in_valid` out 1: one-cycle capture strobe, connected to the stash.
- `next_sample` out 1: one-cycle advance strobe, connected to the stash.
- `show_stash` out 1: display select. 1 selects the stash output, 0 selects `time_in`.
- `stored_cnt` out clog2(DEPTH+1): number of valid samples, saturating at DEPTH.
- `sel_idx` out max(1,clog2(DEPTH)): mirror of the stash read slot.

## Operation
- States: LIVE, BROWSE, AUTO. `show_stash` = 0 in LIVE and 1 in BROWSE and AUTO.
- Internal `wr_ptr` (0..DEPTH-1) mirrors the stash write pointer.
- **Capture** (valid in any state):
  - `lap_btn`=1 with `run`=1 → registers `sample_in`=`time_in` and pulses `sample_in_valid`.
  - On the same edge: `sel_idx`←`wr_ptr`, `wr_ptr`←`wr_ptr`+1 wrapping DEPTH-1→0, `stored_cnt`←min(`stored_cnt`+1, DEPTH).
  - `lap_btn` with `run`=0 is ignored.
  - A capture does not change state. In AUTO it clears the scroll timer.
- **LIVE:**
  - `browse_btn` with `stored_cnt`>0 → BROWSE. No advance is issued on entry.
  - `browse_btn` with `stored_cnt`=0 is ignored.
  - `auto_btn` is ignored.
- **BROWSE:**
  - `browse_btn` → advance request.
  - `auto_btn` → AUTO, timer cleared.
  - `exit_btn` → LIVE.
- **AUTO:**
  - Timer counts 0..AUTO_PERIOD-1. At terminal count it issues an advance request and reloads to 0.
  - `browse_btn` → BROWSE with no advance.
  - `exit_btn` → LIVE.
- **Advance:** pulses `next_sample`; `sel_idx`←`sel_idx`+1 wrapping DEPTH-1→0.
- **Collision rule:** `sample_in_valid` and `next_sample` are never high in the same cycle.
  - An advance request in a capture cycle sets a pending flag instead of pulsing.
  - The pending advance issues in the first subsequent cycle without a capture.
  - Multiple pending requests merge into one.
  - `exit_btn` clears the pending flag.
- **Priority** within a cycle: `exit_btn` > `browse_btn` > `auto_btn` > timer. Capture is independent of this ordering.
- **Reset** (asynchronous): state LIVE; all counters, pointers, and the pending flag = 0.

## Timing
- All outputs are registered.
- Reset values: `sample_in`=0, `sample_in_valid`=0, `next_sample`=0, `show_stash`=0, `stored_cnt`=0, `sel_idx`=0.
- `lap_btn` at edge n → `sample_in_valid`=1 during cycle n+1, with `sample_in` = `time_in` sampled at n.
- `browse_btn` at edge n:
  - `next_sample` during n+1, or n+1+k when captures occupy n+1..n+k.
  - `show_stash`/state changes are visible in n+1.
- AUTO: first advance comes AUTO_PERIOD cycles after entry. Subsequent advances are every AUTO_PERIOD cycles.
- `reset` asserted mid-pulse forces the strobes low immediately. The pending flag is lost.

## Structure
- `stash_ctrl_pkg`: state enum (LIVE/BROWSE/AUTO) and pointer/count width functions derived from DEPTH.
- One sub-module, `auto_timer`:
  - Parameterised terminal count, with clear and enable inputs.
  - Produces a one-cycle `tick` output.
- FSM, pointers, and collision logic stay in `stash_ctrl`.

## Test plan
- Reset, then `run`=1, then 3 lap pulses 2 cycles apart with `time_in`=0x11,0x22,0x33 → three `sample_in_valid` pulses carrying 0x11,0x22,0x33; `stored_cnt`=3; `sel_idx`=2; `show_stash`=0.
- DEPTH=5: capture 7 samples → `stored_cnt` saturates at 5, `wr_ptr` wraps to 2, `sel_idx`=1.
- Browse with `stored_cnt`=0: `browse_btn` → state stays LIVE, no `next_sample`.
- Browse with `stored_cnt`>0:
  - `browse_btn` → BROWSE, no pulse.
  - Second `browse_btn` → one `next_sample`, `sel_idx` increments.
  - `exit_btn` → `show_stash`=0.
- Collision: `lap_btn` and `browse_btn` in BROWSE on the same edge → `sample_in_valid` at n+1, `next_sample` at n+2, never overlapping. Back-to-back laps delay the advance further.
- AUTO with AUTO_PERIOD=4: `next_sample` every 4 cycles. A lap mid-period restarts the timer. Asserting `reset` mid-AUTO → all outputs 0 in the same cycle, state LIVE.
